// File: rtl/matmul_uart_sequencer.sv
// Byte-level command sequencer between the UART byte streams and the matmul engine.
// Loads operands A/B, starts the engine and streams results back MSB first.
module matmul_uart_sequencer #(
    parameter int N           = 2,
    parameter int DW          = 8,
    parameter int RW          = 16,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int NE = N * N,
    localparam int AW = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          ld_we,
    output logic          ld_sel,
    output logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          mm_start,
    input  logic          mm_done,
    output logic [AW-1:0] res_addr,
    input  logic [RW-1:0] res_data,
    output logic          busy
);

    localparam int IW = $clog2(NE + 1);
    localparam int NB = RW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ,
        S_SEND,
        S_ACK,
        S_ERR
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic [TW-1:0] tmo;
    logic [BW-1:0] bcnt;
    logic [RW-1:0] sh;
    logic [RW-1:0] sh_next;
    logic          rd_ph;
    logic          tmo_hit;

    assign idx_inc = idx + IW'(1);
    assign sh_next = sh << 8;
    assign tmo_hit = (tmo == TW'(TIMEOUT_CYC - 1));
    assign busy    = (state != S_IDLE);

    // Command sequencer: one FSM owns every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            tmo      <= '0;
            bcnt     <= '0;
            sh       <= '0;
            rd_ph    <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            ld_we    <= 1'b0;
            ld_sel   <= 1'b0;
            ld_addr  <= '0;
            ld_data  <= '0;
            mm_start <= 1'b0;
            res_addr <= '0;
        end else begin
            ld_we    <= 1'b0;
            mm_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            8'hA1: begin
                                ld_sel <= 1'b0;
                                idx    <= '0;
                                tmo    <= '0;
                                state  <= S_LOAD;
                            end
                            8'hB2: begin
                                ld_sel <= 1'b1;
                                idx    <= '0;
                                tmo    <= '0;
                                state  <= S_LOAD;
                            end
                            8'hC3: state <= S_START;
                            default: begin
                                tx_data  <= 8'hEE;
                                tx_valid <= 1'b1;
                                state    <= S_ERR;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (rx_valid) begin
                        ld_we   <= 1'b1;
                        ld_addr <= idx[AW-1:0];
                        ld_data <= rx_data[DW-1:0];
                        idx     <= idx_inc;
                        tmo     <= '0;
                        if (idx == IW'(NE - 1)) begin
                            tx_data  <= 8'h55;
                            tx_valid <= 1'b1;
                            state    <= S_ACK;
                        end
                    end else if (tmo_hit) begin
                        tx_data  <= 8'hEE;
                        tx_valid <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                S_START: begin
                    mm_start <= 1'b1;
                    tmo      <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mm_done) begin
                        idx      <= '0;
                        res_addr <= '0;
                        rd_ph    <= 1'b0;
                        state    <= S_READ;
                    end else if (tmo_hit) begin
                        tx_data  <= 8'hEE;
                        tx_valid <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                S_READ: begin
                    // res_addr is presented in phase 0, data lands in phase 1.
                    if (!rd_ph) begin
                        rd_ph <= 1'b1;
                    end else begin
                        rd_ph    <= 1'b0;
                        sh       <= res_data;
                        tx_data  <= res_data[RW-1 -: 8];
                        tx_valid <= 1'b1;
                        bcnt     <= '0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        sh <= sh_next;
                        if (bcnt == BW'(NB - 1)) begin
                            tx_valid <= 1'b0;
                            idx      <= idx_inc;
                            if (idx == IW'(NE - 1)) begin
                                state <= S_IDLE;
                            end else begin
                                res_addr <= idx_inc[AW-1:0];
                                state    <= S_READ;
                            end
                        end else begin
                            bcnt    <= bcnt + BW'(1);
                            tx_data <= sh_next[RW-1 -: 8];
                        end
                    end
                end
                S_ACK, S_ERR: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_uart_sequencer.sv
// Randomized bench for matmul_uart_sequencer with a behavioural engine
// and a reference model of the expected host byte stream.
module tb_matmul_uart_sequencer;

    localparam int N   = 2;
    localparam int NE  = N * N;
    localparam int DW  = 8;
    localparam int RW  = 16;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ld_we;
    logic        ld_sel;
    logic [1:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        mm_start;
    logic        mm_done;
    logic [1:0]  res_addr;
    logic [15:0] res_data;
    logic        busy;

    matmul_uart_sequencer #(
        .N(N), .DW(DW), .RW(RW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .mm_start(mm_start), .mm_done(mm_done),
        .res_addr(res_addr), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural engine: operand memories, product, synchronous result read.
    logic [7:0]  a_mem [NE];
    logic [7:0]  b_mem [NE];
    logic [15:0] c_mem [NE];
    int          eng_cnt = 0;
    int          eng_lat = 5;
    logic        eng_done = 1'b0;
    logic        spur_done = 1'b0;

    assign mm_done = eng_done | spur_done;

    always @(posedge clk) begin
        eng_done <= 1'b0;
        res_data <= c_mem[res_addr];
        if (ld_we) begin
            if (ld_sel) b_mem[ld_addr] <= ld_data;
            else        a_mem[ld_addr] <= ld_data;
        end
        if (mm_start) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    int s;
                    s = 0;
                    for (int k = 0; k < N; k++)
                        s += int'(a_mem[r*N+k]) * int'(b_mem[k*N+c]);
                    c_mem[r*N+c] <= s[15:0];
                end
            end
            eng_cnt <= eng_lat;
        end else if (eng_cnt == 1) begin
            eng_done <= 1'b1;
            eng_cnt  <= 0;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    // Monitors sampled on the falling edge.
    logic [7:0]  got_q [$];
    logic [10:0] wr_q [$];
    logic [10:0] exp_wr [$];
    int          start_cnt = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (ld_we) wr_q.push_back({ld_sel, ld_addr, ld_data});
        if (mm_start) start_cnt++;
        if (rst_n && prev_stall && (!tx_valid || tx_data != prev_data))
            stab_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    // Transmitter back-pressure: 0 random, 1 held low.
    int rdy_mode = 0;

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) tx_ready = 1'b0;
            else tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic [7:0] ref_a [NE];
    logic [7:0] ref_b [NE];

    function automatic logic [8:0] got_at(input int i);
        if (got_q.size() > i) return {1'b0, got_q[i]};
        return 9'h1FF;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic wait_bytes(input int n, input int budget,
                              input string tag, output int cyc);
        cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_arrive"}, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_cnt"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            chk({tag, "_wr"}, (i < wr_q.size()) ? wr_q[i] : 11'h7FF, exp_wr[i]);
    endtask

    task automatic do_load(input bit sel, input logic [8*NE-1:0] vals,
                           input string tag);
        int c;
        got_q.delete();
        wr_q.delete();
        exp_wr.delete();
        send_byte(sel ? 8'hB2 : 8'hA1);
        for (int i = 0; i < NE; i++) begin
            logic [7:0] v;
            v = vals[8*i +: 8];
            send_byte(v);
            exp_wr.push_back({sel, 2'(i), v});
            if (sel) ref_b[i] = v;
            else     ref_a[i] = v;
        end
        wait_bytes(1, 300, tag, c);
        chk({tag, "_ack"}, got_at(0), 9'h055);
        check_writes(tag);
        wait_idle(tag);
        chk({tag, "_nbytes"}, got_q.size(), 1);
    endtask

    task automatic do_compute(input bit inject, input bit stall,
                              input string tag);
        logic [7:0] exp_b [$];
        int c;
        got_q.delete();
        wr_q.delete();
        start_cnt = 0;
        for (int i = 0; i < NE; i++) begin
            int s;
            logic [15:0] v;
            s = 0;
            for (int k = 0; k < N; k++)
                s += int'(ref_a[(i/N)*N+k]) * int'(ref_b[k*N+(i%N)]);
            v = s[15:0];
            exp_b.push_back(v[15:8]);
            exp_b.push_back(v[7:0]);
        end
        send_byte(8'hC3);
        if (inject) repeat (3) send_byte(8'($urandom));
        wait_bytes(2, 500, tag, c);
        if (inject || stall) begin
            rdy_mode = 1;
            if (inject) begin
                send_byte(8'hA1);
                send_byte(8'h7F);
                send_byte(8'hC3);
            end
            if (stall) repeat (50) @(posedge clk);
            rdy_mode = 0;
        end
        wait_bytes(exp_b.size(), 500, tag, c);
        wait_idle(tag);
        chk({tag, "_nbytes"}, got_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            chk({tag, "_res"}, got_at(i), {1'b0, exp_b[i]});
        chk({tag, "_starts"}, start_cnt, 1);
        chk({tag, "_no_wr"}, wr_q.size(), 0);
        chk({tag, "_stable"}, stab_err, 0);
    endtask

    initial begin
        int c;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_ld_we", 32'(ld_we), 0);
        chk("rst_mm_start", 32'(mm_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addrs", {ld_addr, res_addr, ld_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed operands from the reference example.
        do_load(1'b0, 32'h04030201, "t1_a");
        do_load(1'b1, 32'h08070605, "t1_b");
        eng_lat = 5;
        do_compute(1'b0, 1'b0, "t1_c");

        // Unknown command, plus a stray mm_done while idle.
        got_q.delete();
        wr_q.delete();
        start_cnt = 0;
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        @(negedge clk);
        chk("t2_spur_busy", 32'(busy), 0);
        send_byte(8'h7F);
        wait_bytes(1, 100, "t2", c);
        chk("t2_err", got_at(0), 9'h0EE);
        wait_idle("t2");
        chk("t2_nbytes", got_q.size(), 1);
        chk("t2_no_wr", wr_q.size(), 0);
        chk("t2_no_start", start_cnt, 0);

        // Load timeout after two elements.
        got_q.delete();
        wr_q.delete();
        exp_wr.delete();
        send_byte(8'hA1);
        send_byte(8'h01);
        send_byte(8'h02);
        ref_a[0] = 8'h01;
        ref_a[1] = 8'h02;
        exp_wr.push_back({1'b0, 2'd0, 8'h01});
        exp_wr.push_back({1'b0, 2'd1, 8'h02});
        wait_bytes(1, TMO + 100, "t3", c);
        chk("t3_err", got_at(0), 9'h0EE);
        chk("t3_not_early", 32'(c >= TMO - 10), 1);
        chk("t3_not_late", 32'(c <= TMO + 30), 1);
        check_writes("t3");
        wait_idle("t3");

        // Back-pressure during the result stream.
        do_load(1'b0, 32'h04030201, "t4_a");
        do_compute(1'b0, 1'b1, "t4_c");

        // Stray host bytes during WAIT and SEND.
        eng_lat = 40;
        do_compute(1'b1, 1'b0, "t5_c");

        // Asynchronous reset in the middle of a load frame.
        send_byte(8'hA1);
        send_byte(8'h09);
        send_byte(8'h0A);
        ref_a[0] = 8'h09;
        ref_a[1] = 8'h0A;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_tx_valid", 32'(tx_valid), 0);
        chk("t6_ld_we", 32'(ld_we), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ld_bus", {ld_sel, ld_addr, ld_data}, 0);
        chk("t6_mm_start", 32'(mm_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load(1'b0, 32'h44332211, "t6_a");

        // Randomized operand rounds.
        for (int r = 0; r < 4; r++) begin
            do_load(1'b0, $urandom, "rnd_a");
            do_load(1'b1, $urandom, "rnd_b");
            eng_lat = $urandom_range(1, 30);
            do_compute(1'b0, r[0], "rnd_c");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
